rdma_rc_pdu_parser_mq: RTL

// Streaming multi-QP successor to the single-QP PDU parser. Accepts multi-beat PDUs over a valid/ready stream.

---
 rtl/rdma_rc_pkg.sv | 33 +++
 rtl/rdma_rc_qpn_lookup.sv | 24 ++
 rtl/rdma_rc_pdu_parser_mq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rdma_rc_pkg.sv
// Shared definitions for the RC PDU parser: QP state codes, opcode class bounds,
// header geometry and the result flag record.
package rdma_rc_pkg;

  localparam int unsigned HDR_W = 64;

  localparam logic [2:0] QP_RESET = 3'd0;
  localparam logic [2:0] QP_INIT  = 3'd1;
  localparam logic [2:0] QP_RTR   = 3'd2;
  localparam logic [2:0] QP_RTS   = 3'd3;
  localparam logic [2:0] QP_ERROR = 3'd7;

  localparam logic [7:0] OP_DATA_MAX = 8'h1F;
  localparam logic [7:0] OP_CTRL_MIN = 8'h20;
  localparam logic [7:0] OP_CTRL_MAX = 8'h7F;
  localparam logic [7:0] OP_RSVD_MIN = 8'h80;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } pdu_state_e;

  // Result flags in record order, MSB first
  typedef struct packed {
    logic is_data;
    logic is_ctrl;
    logic opcode_err;
    logic qpn_err;
    logic psn_err;
    logic len_err;
  } rc_flags_t;

endpackage

// File: rtl/rdma_rc_qpn_lookup.sv
// Priority match of a QPN against the context table; lowest matching index wins.
module rdma_rc_qpn_lookup #(
  parameter int unsigned NUM_QP    = 4,
  parameter int unsigned QPN_WIDTH = 16,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [QPN_WIDTH*NUM_QP-1:0] qp_qpn,
  input  logic [QPN_WIDTH-1:0]        qpn,
  output logic                        hit_c,
  output logic [IDX_W-1:0]            idx_c
);

  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int unsigned i = 0; i < NUM_QP; i++) begin
      if (!hit_c && (qp_qpn[i*QPN_WIDTH +: QPN_WIDTH] == qpn)) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rdma_rc_pdu_parser_mq.sv
// Multi-QP RC PDU parser: decodes the header beat, checks opcode/QPN/PSN per QP
// context and emits one result record per PDU through a one-deep result register.
module rdma_rc_pdu_parser_mq
  import rdma_rc_pkg::*;
#(
  parameter int unsigned NUM_QP        = 4,
  parameter int unsigned QPN_WIDTH     = 16,
  parameter int unsigned PSN_WIDTH     = 24,
  parameter int unsigned OPCODE_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned OPCODE_OFFSET = 56,
  parameter int unsigned QPN_OFFSET    = 32,
  parameter int unsigned PSN_OFFSET    = 8,
  parameter int unsigned MAX_BEATS     = 64,
  localparam int unsigned QP_IDX_W     = (NUM_QP > 1) ? $clog2(NUM_QP) : 1,
  localparam int unsigned BEAT_W       = $clog2(MAX_BEATS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  input  logic [3*NUM_QP-1:0]         qp_state,
  input  logic [QPN_WIDTH*NUM_QP-1:0] qp_qpn,
  input  logic                        psn_init_we,
  input  logic [QP_IDX_W-1:0]         psn_init_idx,
  input  logic [PSN_WIDTH-1:0]        psn_init_val,
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [OPCODE_WIDTH-1:0]     r_opcode,
  output logic [QPN_WIDTH-1:0]        r_qpn,
  output logic [PSN_WIDTH-1:0]        r_psn,
  output logic [QP_IDX_W-1:0]         r_qp_idx,
  output logic                        r_is_data,
  output logic                        r_is_ctrl,
  output logic [BEAT_W-1:0]           r_beats,
  output logic                        r_opcode_err,
  output logic                        r_qpn_err,
  output logic                        r_psn_err,
  output logic                        r_len_err
);

  pdu_state_e state_q, state_n;
  logic run_q, beat_acc_c, hdr_beat_c, done_c;
  logic [HDR_W-1:0] hdr_c;
  logic [OPCODE_WIDTH-1:0] dec_op_c, op_q, cur_op_c;
  logic [QPN_WIDTH-1:0] dec_qpn_c, qpn_q, cur_qpn_c;
  logic [PSN_WIDTH-1:0] dec_psn_c, psn_q, cur_psn_c, cur_exp_c;
  logic lk_hit_c, hit_q, cur_hit_c;
  logic [QP_IDX_W-1:0] lk_idx_c, idx_q, cur_idx_c;
  logic [2:0] lk_st_c, st_q, cur_st_c;
  logic [BEAT_W-1:0] beats_q, cur_beats_c;
  logic ovf_q, cur_ovf_c, psn_inc_c;
  logic [PSN_WIDTH-1:0] exp_psn_q [NUM_QP];
  rc_flags_t flags_c, flags_q;
  logic unused_data_c;

  // Header fields and context lookup from the current beat
  assign hdr_c     = s_data[DATA_WIDTH-HDR_W +: HDR_W];
  assign dec_op_c  = hdr_c[OPCODE_OFFSET +: OPCODE_WIDTH];
  assign dec_qpn_c = hdr_c[QPN_OFFSET +: QPN_WIDTH];
  assign dec_psn_c = hdr_c[PSN_OFFSET +: PSN_WIDTH];
  assign unused_data_c = ^s_data;

  rdma_rc_qpn_lookup #(
    .NUM_QP    (NUM_QP),
    .QPN_WIDTH (QPN_WIDTH),
    .IDX_W     (QP_IDX_W)
  ) u_lookup (
    .qp_qpn (qp_qpn),
    .qpn    (dec_qpn_c),
    .hit_c  (lk_hit_c),
    .idx_c  (lk_idx_c)
  );

  always_comb begin
    lk_st_c = '0;
    for (int unsigned i = 0; i < NUM_QP; i++) begin
      if (lk_idx_c == QP_IDX_W'(i)) lk_st_c = qp_state[3*i +: 3];
    end
  end

  // A single-beat PDU completes on its header beat, so the live decode bypasses the latches
  assign cur_op_c    = hdr_beat_c ? dec_op_c  : op_q;
  assign cur_qpn_c   = hdr_beat_c ? dec_qpn_c : qpn_q;
  assign cur_psn_c   = hdr_beat_c ? dec_psn_c : psn_q;
  assign cur_hit_c   = hdr_beat_c ? lk_hit_c  : hit_q;
  assign cur_idx_c   = hdr_beat_c ? lk_idx_c  : idx_q;
  assign cur_st_c    = hdr_beat_c ? lk_st_c   : st_q;
  assign cur_beats_c = hdr_beat_c ? BEAT_W'(1) :
                       (beats_q == BEAT_W'(MAX_BEATS)) ? beats_q : beats_q + BEAT_W'(1);
  assign cur_ovf_c   = hdr_beat_c ? 1'b0 : (ovf_q | (beats_q == BEAT_W'(MAX_BEATS)));

  always_comb begin
    cur_exp_c = '0;
    for (int unsigned i = 0; i < NUM_QP; i++) begin
      if (cur_idx_c == QP_IDX_W'(i)) cur_exp_c = exp_psn_q[i];
    end
  end

  always_comb begin
    flags_c            = '0;
    flags_c.is_data    = (cur_op_c <= OPCODE_WIDTH'(OP_DATA_MAX));
    flags_c.is_ctrl    = (cur_op_c >= OPCODE_WIDTH'(OP_CTRL_MIN)) &&
                         (cur_op_c <= OPCODE_WIDTH'(OP_CTRL_MAX));
    flags_c.qpn_err    = !cur_hit_c;
    flags_c.len_err    = cur_ovf_c;
    if (cur_hit_c) begin
      if (cur_op_c >= OPCODE_WIDTH'(OP_RSVD_MIN)) flags_c.opcode_err = 1'b1;
      else if (cur_st_c == QP_RTS)                flags_c.opcode_err = !flags_c.is_data;
      else if (cur_st_c == QP_RTR)                flags_c.opcode_err = !flags_c.is_ctrl;
      else                                        flags_c.opcode_err = 1'b1;
      flags_c.psn_err = (cur_st_c == QP_RTS) && flags_c.is_data && (cur_psn_c != cur_exp_c);
    end
  end

  assign psn_inc_c = done_c && cur_hit_c && (cur_st_c == QP_RTS) && flags_c.is_data &&
                     !flags_c.opcode_err && !flags_c.psn_err && !flags_c.len_err;

  assign s_ready    = run_q && (!r_valid || r_ready);
  assign beat_acc_c = s_valid && s_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HDR;
    else        state_q <= state_n;
  end

  // FSM next state
  always_comb begin
    state_n = state_q;
    if (beat_acc_c) begin
      case (state_q)
        ST_HDR:  if (!s_last) state_n = ST_BODY;
        ST_BODY: if (s_last)  state_n = ST_HDR;
        default: state_n = ST_HDR;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    hdr_beat_c = 1'b0;
    done_c     = 1'b0;
    if (state_q == ST_HDR) hdr_beat_c = 1'b1;
    if (beat_acc_c)        done_c     = s_last;
  end

  // Per-PDU latches and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      op_q    <= '0;
      qpn_q   <= '0;
      psn_q   <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      st_q    <= '0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (beat_acc_c) begin
        op_q    <= cur_op_c;
        qpn_q   <= cur_qpn_c;
        psn_q   <= cur_psn_c;
        hit_q   <= cur_hit_c;
        idx_q   <= cur_idx_c;
        st_q    <= cur_st_c;
        beats_q <= cur_beats_c;
        ovf_q   <= cur_ovf_c;
      end
    end
  end

  // Expected PSN per context; an init write wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_QP; i++) exp_psn_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_QP; i++) begin
        if (psn_init_we && (psn_init_idx == QP_IDX_W'(i)))
          exp_psn_q[i] <= psn_init_val;
        else if (psn_inc_c && (cur_idx_c == QP_IDX_W'(i)))
          exp_psn_q[i] <= exp_psn_q[i] + PSN_WIDTH'(1);
      end
    end
  end

  // Result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_opcode <= '0;
      r_qpn    <= '0;
      r_psn    <= '0;
      r_qp_idx <= '0;
      r_beats  <= '0;
      flags_q  <= '0;
    end else if (done_c) begin
      r_valid  <= 1'b1;
      r_opcode <= cur_op_c;
      r_qpn    <= cur_qpn_c;
      r_psn    <= cur_psn_c;
      r_qp_idx <= cur_idx_c;
      r_beats  <= cur_beats_c;
      flags_q  <= flags_c;
    end else if (r_valid && r_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign r_is_data    = flags_q.is_data;
  assign r_is_ctrl    = flags_q.is_ctrl;
  assign r_opcode_err = flags_q.opcode_err;
  assign r_qpn_err    = flags_q.qpn_err;
  assign r_psn_err    = flags_q.psn_err;
  assign r_len_err    = flags_q.len_err;

endmodule
